// File: rtl/mult_share_arbiter.sv
// Round-robin, burst-locked arbiter that shares one pipelined 256x256->512 multiplier.
// Define MULT_ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins) at every arbitration.
module mult_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic [NUM_REQ*256-1:0]   op_a_in,
  input  logic [NUM_REQ*256-1:0]   op_b_in,
  output logic [255:0]             mult_in_0,
  output logic [255:0]             mult_in_1,
  input  logic [511:0]             mult_out_512,
  output logic [NUM_REQ-1:0]       res_valid,
  output logic [511:0]             res_out,
  output logic                     busy,
  output logic [1:0]               state_dbg
);

`ifdef MULT_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  // Handshake: req[i] is held high for the whole burst. While gnt[i] is high
  // (state ARB_BUSY), every cycle with req[i] high issues one operation; the
  // first cycle with req[i] low ends the burst and is followed by one dead
  // ARB_HANDOFF cycle. res_valid[i] strobes exactly LATENCY cycles after issue.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_HANDOFF = 2'd2
  } arb_state_t;

  arb_state_t          state_q, state_d;
  // The current owner and the last owner are always the same value.
  logic [1:0]          last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [1:0]          winner, win_hi, win_lo;
  logic                found_hi;
  logic                issue;
  logic                tag_v  [LATENCY];
  logic [1:0]          tag_id [LATENCY];

  // Lowest requester above last_owner, else lowest requester overall.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_lo = 2'(i);
        if (2'(i) > last_owner_q) begin
          win_hi   = 2'(i);
          found_hi = 1'b1;
        end
      end
    end
    winner = (found_hi && !FIXED_PRIO) ? win_hi : win_lo;
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    case (state_q)
      ARB_IDLE, ARB_HANDOFF: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
        if (|req) begin
          state_d      = ARB_BUSY;
          last_owner_d = winner;
          for (int i = 0; i < NUM_REQ; i++) gnt_d[i] = (winner == 2'(i));
        end
      end
      ARB_BUSY: begin
        if (!(|(req & gnt_q))) begin
          state_d = ARB_HANDOFF;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= 2'(NUM_REQ - 1);
      gnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
    end
  end

  // In ARB_BUSY gnt_q is the one-hot owner, so it doubles as the operand select.
  assign issue = (state_q == ARB_BUSY) && (|(req & gnt_q));

  always_comb begin
    mult_in_0 = '0;
    mult_in_1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (issue && gnt_q[i]) begin
        mult_in_0 = op_a_in[256*i +: 256];
        mult_in_1 = op_b_in[256*i +: 256];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= '0;
      end
    end else begin
      tag_v[0]  <= issue;
      tag_id[0] <= last_owner_q;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_comb begin
    res_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      res_valid[i] = tag_v[LATENCY-1] && (tag_id[LATENCY-1] == 2'(i));
  end

  assign res_out   = mult_out_512;
  assign gnt       = gnt_q;
  assign busy      = (state_q == ARB_BUSY) || (state_q == ARB_HANDOFF);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: grants, handoff, tag routing, reset and idle behaviour.
// A behavioural LATENCY-deep multiplier model closes the loop from mult_in_0/1 to mult_out_512.
module tb_mult_share_arbiter;
  localparam int NR  = 2;
  localparam int LAT = 10;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NR-1:0]       req = '0;
  logic [NR-1:0]       gnt;
  logic [NR*256-1:0]   op_a_in = '0;
  logic [NR*256-1:0]   op_b_in = '0;
  logic [255:0]        mult_in_0, mult_in_1;
  logic [511:0]        mult_out_512;
  logic [NR-1:0]       res_valid;
  logic [511:0]        res_out;
  logic                busy;
  logic [1:0]          state_dbg;
  logic [511:0]        mpipe [LAT];

  int n_vec = 0;
  int n_err = 0;

  mult_share_arbiter #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .op_a_in(op_a_in), .op_b_in(op_b_in),
    .mult_in_0(mult_in_0), .mult_in_1(mult_in_1),
    .mult_out_512(mult_out_512), .res_valid(res_valid),
    .res_out(res_out), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // multiplier model
  always @(posedge clk) begin
    mpipe[0] <= {256'd0, mult_in_0} * {256'd0, mult_in_1};
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mult_out_512 = mpipe[LAT-1];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_ops(input int idx, input logic [255:0] a, input logic [255:0] b);
    op_a_in[256*idx +: 256] = a;
    op_b_in[256*idx +: 256] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 2'b11;
    set_ops(0, 256'd3, 256'd4);
    set_ops(1, 256'd5, 256'd6);
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (gnt !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    n_vec++; if (res_valid !== 2'b00) begin n_err++; $display("FAIL reset_rv: got %b want 00", res_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    n_vec++; if (mult_in_0 !== 256'd0) begin n_err++; $display("FAIL reset_min0: got %0h want 0", mult_in_0); end
    req = 2'b00;
    set_ops(0, 256'd0, 256'd0);
    set_ops(1, 256'd0, 256'd0);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [255:0] big;
    logic [511:0] exp_res;
    logic [255:0] exp_m0, exp_m1;
    logic [1:0]   exp_g, exp_rv;
    big = 256'd1 << 255;
    do_reset();
    req = 2'b01;
    for (int c = 1; c <= 14; c++) begin
      step();
      case (c)
        1: set_ops(0, 256'd3, 256'd5);
        2: set_ops(0, 256'd7, 256'd11);
        3: set_ops(0, big, 256'd2);
        default: begin req = 2'b00; set_ops(0, 256'd9, 256'd9); end
      endcase
      #1;
      exp_g  = (c <= 4) ? 2'b01 : 2'b00;
      exp_rv = (c >= 11 && c <= 13) ? 2'b01 : 2'b00;
      exp_m0 = (c == 1) ? 256'd3 : (c == 2) ? 256'd7 : (c == 3) ? big : 256'd0;
      exp_m1 = (c == 1) ? 256'd5 : (c == 2) ? 256'd11 : (c == 3) ? 256'd2 : 256'd0;
      exp_res = (c == 11) ? 512'd15 : (c == 12) ? 512'd77 : (512'd1 << 256);
      n_vec++; if (gnt !== exp_g) begin n_err++; $display("FAIL single_gnt c%0d: got %b want %b", c, gnt, exp_g); end
      n_vec++; if (busy !== (c <= 5)) begin n_err++; $display("FAIL single_busy c%0d: got %b want %b", c, busy, (c <= 5)); end
      n_vec++; if (res_valid !== exp_rv) begin n_err++; $display("FAIL single_rv c%0d: got %b want %b", c, res_valid, exp_rv); end
      n_vec++; if (mult_in_0 !== exp_m0 || mult_in_1 !== exp_m1) begin
        n_err++; $display("FAIL single_min c%0d: got %0h*%0h want %0h*%0h", c, mult_in_0, mult_in_1, exp_m0, exp_m1);
      end
      if (exp_rv != 2'b00) begin
        n_vec++; if (res_out !== exp_res) begin n_err++; $display("FAIL single_res c%0d: got %0h want %0h", c, res_out, exp_res); end
      end
    end
  endtask

  task automatic test_handoff_routing();
    logic [1:0]   exp_g, exp_rv;
    logic [255:0] exp_m0;
    logic [511:0] exp_res;
    do_reset();
    req = 2'b11;
    for (int c = 1; c <= 18; c++) begin
      step();
      req = (c <= 2) ? 2'b11 : (c == 3) ? 2'b10 : (c <= 6) ? 2'b11 : (c <= 8) ? 2'b01 : 2'b00;
      set_ops(0, 256'(c + 1), 256'(c + 2));
      set_ops(1, 256'(c + 10), 256'(c + 20));
      #1;
      exp_g  = (c <= 3) ? 2'b01 : (c == 4) ? 2'b00 : (c <= 7) ? 2'b10 : (c == 9) ? 2'b01 : 2'b00;
      exp_m0 = (c == 1) ? 256'd2 : (c == 2) ? 256'd3 : (c == 5) ? 256'd15 : (c == 6) ? 256'd16 : 256'd0;
      exp_rv = (c == 11 || c == 12) ? 2'b01 : (c == 15 || c == 16) ? 2'b10 : 2'b00;
      exp_res = (c == 11) ? 512'd6 : (c == 12) ? 512'd12 : (c == 15) ? 512'd375 : 512'd416;
      n_vec++; if (gnt !== exp_g) begin n_err++; $display("FAIL handoff_gnt c%0d: got %b want %b", c, gnt, exp_g); end
      n_vec++; if (busy !== (c <= 10)) begin n_err++; $display("FAIL handoff_busy c%0d: got %b want %b", c, busy, (c <= 10)); end
      n_vec++; if (mult_in_0 !== exp_m0) begin n_err++; $display("FAIL handoff_min0 c%0d: got %0h want %0h", c, mult_in_0, exp_m0); end
      n_vec++; if (res_valid !== exp_rv) begin n_err++; $display("FAIL handoff_rv c%0d: got %b want %b", c, res_valid, exp_rv); end
      if (exp_rv != 2'b00) begin
        n_vec++; if (res_out !== exp_res) begin n_err++; $display("FAIL handoff_res c%0d: got %0h want %0h", c, res_out, exp_res); end
      end
      if (c == 4 || c == 8) begin
        n_vec++; if (state_dbg !== 2'd2) begin n_err++; $display("FAIL handoff_state c%0d: got %0d want 2", c, state_dbg); end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req = 2'b10;
    set_ops(1, 256'd5, 256'd5);
    for (int c = 1; c <= 5; c++) begin
      step();
      n_vec++; if (gnt !== 2'b10) begin n_err++; $display("FAIL rstmid_gnt c%0d: got %b want 10", c, gnt); end
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (gnt !== 2'b00) begin n_err++; $display("FAIL rstmid_gnt_async: got %b want 00", gnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy_async: got %b want 0", busy); end
    n_vec++; if (res_valid !== 2'b00) begin n_err++; $display("FAIL rstmid_rv_async: got %b want 00", res_valid); end
    req = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 2 * LAT; c++) begin
      step();
      n_vec++; if (res_valid !== 2'b00 || gnt !== 2'b00) begin
        n_err++; $display("FAIL rstmid_quiet c%0d: got rv=%b gnt=%b want 00/00", c, res_valid, gnt);
      end
    end
    req = 2'b10;
    step();
    n_vec++; if (gnt !== 2'b10) begin n_err++; $display("FAIL rstmid_regrant: got %b want 10", gnt); end
    req = 2'b00;
  endtask

  task automatic test_idle_inputs();
    do_reset();
    req = 2'b00;
    for (int c = 1; c <= LAT + 3; c++) begin
      op_a_in = {16{c}};
      op_b_in = {16{~c}};
      #1;
      n_vec++; if (mult_in_0 !== 256'd0 || mult_in_1 !== 256'd0) begin
        n_err++; $display("FAIL idle_min c%0d: got %0h/%0h want 0/0", c, mult_in_0, mult_in_1);
      end
      n_vec++; if (res_valid !== 2'b00 || gnt !== 2'b00) begin
        n_err++; $display("FAIL idle_out c%0d: got rv=%b gnt=%b want 00/00", c, res_valid, gnt);
      end
      step();
    end
    op_a_in = '0;
    op_b_in = '0;
  endtask

  // Both requesters keep asking, each dropping req for one cycle after a single issue.
  task automatic test_arbitration_policy();
    logic [1:0] g_last, r_last, exp_g;
    int phase, round;
    do_reset();
    req = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      g_last = gnt;
      r_last = req;
      step();
      req = ~(g_last & r_last);
      #1;
      phase = (c - 1) % 3;
      round = (c - 1) / 3;
`ifdef MULT_ARB_FIXED_PRIORITY_EN
      exp_g = (phase == 2) ? 2'b00 : 2'b01;
`else
      exp_g = (phase == 2) ? 2'b00 : ((round % 2) == 1) ? 2'b10 : 2'b01;
`endif
      n_vec++; if (gnt !== exp_g) begin n_err++; $display("FAIL policy_gnt c%0d: got %b want %b", c, gnt, exp_g); end
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_handoff_routing();
    test_reset_mid_op();
    test_idle_inputs();
    test_arbitration_policy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
